// File: rtl/ppu_cfg_loader.sv
// Config-table feeder for the ppu: streams NBYTES table bytes over the ppu input
// handshake, then acks the ppu output stream and registers each byte onto wb_data.
module ppu_cfg_loader #(
  parameter int unsigned NBYTES  = 10,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_pix,
  input  logic          sim_rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_wdata,
  input  logic [2:0]    mode_sel,
  input  logic          reload_req,
  input  logic          frame_start,
  output logic          ppu_sync,
  output logic [2:0]    ppu_mode,
  output logic [7:0]    ppu_data_i,
  output logic          ppu_stb_i,
  input  logic          ppu_ack_i,
  input  logic [7:0]    ppu_data_o,
  input  logic          ppu_stb_o,
  output logic          ppu_ack_o,
  output logic [7:0]    wb_data,
  output logic          busy,
  output logic          err
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0] r_wait, w_wait_nxt;
  logic          r_pending, w_pending_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_stb, w_stb_nxt;
  logic          r_sync, w_sync_nxt;
  logic [2:0]    r_mode, w_mode_nxt;
  logic [7:0]    r_wb, w_wb_nxt;
  logic          r_err, w_err_nxt;
  logic          r_ack_o, w_ack_o_nxt;
  logic          r_busy, w_busy_nxt;
  logic [7:0]    r_tbl [DEPTH];

  // Config table: writable in any state, cleared by reset.
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_tbl[i] <= '0;
    end else if (cfg_we) begin
      r_tbl[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wait_nxt    = r_wait;
    w_pending_nxt = r_pending | reload_req;
    w_data_nxt    = r_data;
    w_stb_nxt     = r_stb;
    w_sync_nxt    = r_sync;
    w_mode_nxt    = r_mode;
    w_wb_nxt      = r_wb;
    w_err_nxt     = r_err;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_LOAD;
        w_mode_nxt  = mode_sel;
        w_data_nxt  = r_tbl[0];
        w_stb_nxt   = 1'b1;
        w_sync_nxt  = 1'b1;
        w_idx_nxt   = '0;
        w_wait_nxt  = '0;
      end
      ST_LOAD: begin
        if (r_stb && ppu_ack_i) begin
          if (r_idx < AW'(NBYTES - 1)) begin
            w_idx_nxt  = r_idx + AW'(1);
            w_data_nxt = r_tbl[r_idx + AW'(1)];
            w_wait_nxt = '0;
          end else begin
            w_state_nxt = ST_RUN;
            w_stb_nxt   = 1'b0;
            w_sync_nxt  = 1'b0;
            w_data_nxt  = '0;
            w_idx_nxt   = '0;
          end
        end else if (r_wait == TW'(TIMEOUT - 1)) begin
          // ppu never acked this byte: park in ERROR until a frame-aligned reload
          w_state_nxt = ST_ERROR;
          w_stb_nxt   = 1'b0;
          w_sync_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          w_wait_nxt = r_wait + TW'(1);
        end
      end
      ST_RUN: begin
        if (ppu_stb_o) w_wb_nxt = ppu_data_o;
        if (w_pending_nxt && frame_start) begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 1'b0;
          w_err_nxt     = 1'b0;
        end
      end
      ST_ERROR: begin
        if (w_pending_nxt && frame_start) begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 1'b0;
          w_err_nxt     = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ack_o_nxt = (w_state_nxt == ST_RUN);
    w_busy_nxt  = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
  end

  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      r_idx     <= '0;
      r_wait    <= '0;
      r_pending <= 1'b0;
      r_data    <= '0;
      r_stb     <= 1'b0;
      r_sync    <= 1'b0;
      r_mode    <= '0;
      r_wb      <= '0;
      r_err     <= 1'b0;
      r_ack_o   <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_idx     <= w_idx_nxt;
      r_wait    <= w_wait_nxt;
      r_pending <= w_pending_nxt;
      r_data    <= w_data_nxt;
      r_stb     <= w_stb_nxt;
      r_sync    <= w_sync_nxt;
      r_mode    <= w_mode_nxt;
      r_wb      <= w_wb_nxt;
      r_err     <= w_err_nxt;
      r_ack_o   <= w_ack_o_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign ppu_sync   = r_sync;
  assign ppu_mode   = r_mode;
  assign ppu_data_i = r_data;
  assign ppu_stb_i  = r_stb;
  assign ppu_ack_o  = r_ack_o;
  assign wb_data    = r_wb;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule
